// File: rtl/divider_seq_pkg.sv
// divider_seq_pkg: divider widths, iteration count, FSM states and magnitude helper
package divider_seq_pkg;
  localparam int WORD = 32;
  localparam int DIV_ITER = 32;
  typedef enum logic [1:0] {DIV_IDLE, DIV_CALC, DIV_FIX} div_state_t;
  function automatic logic [WORD-1:0] mag(input logic [WORD-1:0] x);
    return x[WORD-1] ? -x : x;
  endfunction
endpackage

// File: rtl/divider_seq_if.sv
// divider_seq_if: DivInit/A_in/B_in requests in, Div_High_Out/Div_Low_Out/DivStop/Zero_Div results out
interface divider_seq_if;
  import divider_seq_pkg::*;
  logic DivInit;
  logic [WORD-1:0] A_in;
  logic [WORD-1:0] B_in;
  logic [WORD-1:0] Div_High_Out;
  logic [WORD-1:0] Div_Low_Out;
  logic DivStop;
  logic Zero_Div;
  modport master (output DivInit, A_in, B_in, input Div_High_Out, Div_Low_Out, DivStop, Zero_Div);
  modport slave (input DivInit, A_in, B_in, output Div_High_Out, Div_Low_Out, DivStop, Zero_Div);
endinterface

// File: rtl/divider_seq_div_step.sv
// divider_seq_div_step: one restoring iteration, {r,q} + divisor d in, next {r_nx,q_nx} out
module divider_seq_div_step
  import divider_seq_pkg::*;
(
  input  logic [WORD:0]   r,
  input  logic [WORD-1:0] q,
  input  logic [WORD-1:0] d,
  output logic [WORD:0]   r_nx,
  output logic [WORD-1:0] q_nx
);
  logic [2*WORD:0] sh;
  logic [WORD:0] trial;
  always_comb begin
    sh = {r, q} << 1;
    trial = sh[2*WORD:WORD] - {1'b0, d};
    r_nx = trial[WORD] ? sh[2*WORD:WORD] : trial;
    q_nx = sh[WORD-1:0] | {{(WORD-1){1'b0}}, ~trial[WORD]};
  end
endmodule

// File: rtl/divider_seq.sv
// divider_seq: signed 32-bit sequential divider, clk/reset plus bus (start, operands, HI/LO results, done and divide-by-zero pulses)
module divider_seq
  import divider_seq_pkg::*;
(
  input logic clk,
  input logic reset,
  divider_seq_if.slave bus
);
  div_state_t state, state_nx;
  logic [4:0] cnt;
  logic [WORD:0] r, r_nx;
  logic [WORD-1:0] q, q_nx, d, hi, lo;
  logic sq, sr, stop, zdiv, start, last;
  divider_seq_div_step u_step (.r(r), .q(q), .d(d), .r_nx(r_nx), .q_nx(q_nx));
  always_comb begin
    start = state == DIV_IDLE && bus.DivInit && |bus.B_in;
    last = state == DIV_CALC && cnt == 5'(DIV_ITER - 1);
    state_nx = start ? DIV_CALC : last ? DIV_FIX : state == DIV_FIX ? DIV_IDLE : state;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= DIV_IDLE;
      cnt <= '0;
      r <= '0;
      q <= '0;
      d <= '0;
      sq <= 1'b0;
      sr <= 1'b0;
      hi <= '0;
      lo <= '0;
      stop <= 1'b0;
      zdiv <= 1'b0;
    end else begin
      state <= state_nx;
      stop <= state == DIV_FIX;
      zdiv <= state == DIV_IDLE && bus.DivInit && ~|bus.B_in;
      if (start) begin
        r <= '0;
        q <= mag(bus.A_in);
        d <= mag(bus.B_in);
        sq <= bus.A_in[WORD-1] ^ bus.B_in[WORD-1];
        sr <= bus.A_in[WORD-1];
        cnt <= '0;
      end else if (state == DIV_CALC) begin
        r <= r_nx;
        q <= q_nx;
        cnt <= cnt + 5'd1;
      end
      if (state == DIV_FIX) begin
        lo <= sq ? -q : q;
        hi <= sr ? -r[WORD-1:0] : r[WORD-1:0];
      end
    end
  assign bus.Div_High_Out = hi;
  assign bus.Div_Low_Out = lo;
  assign bus.DivStop = stop;
  assign bus.Zero_Div = zdiv;
endmodule

// File: tb/tb_divider_seq.sv
// tb_divider_seq: randomized and directed checks of divider_seq against a 64-bit arithmetic model
module tb_divider_seq;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int passed = 0;
  int cyc = 0;
  logic [31:0] e_hi, e_lo, p_hi, p_lo;
  logic e_stop, e_z, busy;
  int cnt;
  always #5 clk = ~clk;
  divider_seq_if bus();
  divider_seq dut (.clk(clk), .reset(reset), .bus(bus));
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    longint la, lb, qq, rr;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    qq = la / lb;
    rr = la % lb;
    return {rr[31:0], qq[31:0]};
  endfunction
  always @(posedge clk or posedge reset)
    if (reset) begin
      busy <= 1'b0;
      cnt <= 0;
      e_hi <= '0;
      e_lo <= '0;
      e_stop <= 1'b0;
      e_z <= 1'b0;
    end else begin
      e_stop <= 1'b0;
      e_z <= 1'b0;
      if (busy) begin
        cnt <= cnt + 1;
        if (cnt == 32) begin
          busy <= 1'b0;
          e_hi <= p_hi;
          e_lo <= p_lo;
          e_stop <= 1'b1;
        end
      end else if (bus.DivInit) begin
        if (bus.B_in == 0) e_z <= 1'b1;
        else begin
          busy <= 1'b1;
          cnt <= 0;
          {p_hi, p_lo} <= ref_div(bus.A_in, bus.B_in);
        end
      end
    end
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask
  always @(negedge clk) begin
    chk("hi", bus.Div_High_Out, e_hi);
    chk("lo", bus.Div_Low_Out, e_lo);
    chk("stop", {31'b0, bus.DivStop}, {31'b0, e_stop});
    chk("zdiv", {31'b0, bus.Zero_Div}, {31'b0, e_z});
  end
  task automatic start(input logic [31:0] a, input logic [31:0] b, output int c0);
    bus.DivInit = 1'b1;
    bus.A_in = a;
    bus.B_in = b;
    @(posedge clk);
    #2;
    c0 = cyc;
    bus.DivInit = 1'b0;
    bus.A_in = $urandom;
    bus.B_in = $urandom;
  endtask
  task automatic wait_stop(input int c0);
    int lat;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.DivStop) begin
        lat = cyc - c0;
        break;
      end
    end
    chk("latency", lat, 33);
  endtask
  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] lo, input logic [31:0] hi);
    int c0;
    start(a, b, c0);
    wait_stop(c0);
    chk("lit_lo", bus.Div_Low_Out, lo);
    chk("lit_hi", bus.Div_High_Out, hi);
  endtask
  initial begin
    int c0, seen, sel;
    logic [31:0] a, b;
    bus.DivInit = 1'b0;
    bus.A_in = '0;
    bus.B_in = '0;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    chk("rst_lo", bus.Div_Low_Out, 0);
    chk("rst_hi", bus.Div_High_Out, 0);
    op(7, 2, 3, 1);
    op(32'hFFFFFFF9, 2, 32'hFFFFFFFD, 32'hFFFFFFFF);
    op(7, 32'hFFFFFFFE, 32'hFFFFFFFD, 1);
    op(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
    op(100, 7, 14, 2);
    start(5, 0, c0);
    @(negedge clk);
    chk("z_pulse", {31'b0, bus.Zero_Div}, 1);
    chk("z_nostop", {31'b0, bus.DivStop}, 0);
    chk("z_lo", bus.Div_Low_Out, 14);
    chk("z_hi", bus.Div_High_Out, 2);
    @(negedge clk);
    chk("z_once", {31'b0, bus.Zero_Div}, 0);
    start(1000, 3, c0);
    repeat (5) @(posedge clk);
    #2;
    bus.DivInit = 1'b1;
    bus.A_in = 77;
    bus.B_in = 5;
    @(posedge clk);
    #2 bus.DivInit = 1'b0;
    wait_stop(c0);
    chk("ign_lo", bus.Div_Low_Out, 333);
    chk("ign_hi", bus.Div_High_Out, 1);
    start(123456, 789, c0);
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_lo", bus.Div_Low_Out, 0);
    chk("mid_rst_hi", bus.Div_High_Out, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.DivStop || bus.Zero_Div) seen++;
    end
    chk("no_pulse_after_rst", seen, 0);
    for (int n = 0; n < 30; n++) begin
      a = $urandom;
      sel = $urandom_range(0, 7);
      b = sel == 0 ? 32'h0 : sel == 1 ? 32'($urandom_range(1, 9)) : sel == 2 ? 32'hFFFFFFFF : $urandom;
      if (sel == 3) a = 32'h80000000;
      start(a, b, c0);
      if (b == 0) @(negedge clk);
      else wait_stop(c0);
    end
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
